bottle_fill_seq: RTL and testbench
==================================

Name: bottle_fill_seq

Overview:
- Sequencer for one bottling lane. It steps the conveyor so a new bottle arrives, then requests pills from the feeder one at a time until the bottle holds the configured pill count.
- It repeats this until the configured number of bottles is filled, then raises all_full for the display and music blocks.
- Sits between the set-max configuration registers (BCD pill/bottle maxima) and the feeder and conveyor actuators. Its BCD counters drive the page display.

Parameters:
- FEED_GAP, 1: idle cycles inserted between one feed handshake completing and the next feed_req.
- TIMEOUT, 255: cycles to wait for feed_ack or conv_ack before faulting. Used only with FILL_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- run  in  1  level enable from the work switch.
- conti  in  1  1 = continuous batch; 0 = single-bottle step mode.
- pill_max_h, pill_max_l  in  4 each  BCD pills per bottle.
- bot_max_h, bot_max_l  in  4 each  BCD bottles per batch.
- feed_req  out  1  request one pill.
- feed_ack  in  1  pill delivered.
- conv_req  out  1  advance conveyor one bottle.
- conv_ack  in  1  bottle in position.
- pill_cnt_h, pill_cnt_l  out  4 each  BCD pills in current bottle.
- bot_cnt_h, bot_cnt_l  out  4 each  BCD bottles completed.
- bottle_done  out  1  one-cycle pulse per filled bottle.
- busy  out  1  state is not IDLE, FULL or HOLD.
- all_full  out  1  batch complete.
- cfg_err  out  1  latched maximum invalid.
- fault  out  1  handshake timeout (optional feature only).

Behaviour:
- Reset (async, RST_n=0): state=IDLE. All counters 0. All outputs 0.
- Configuration latch:
  - On the IDLE->LOAD transition, all four max digits are latched internally.
  - Input changes during a batch are ignored.
  - A digit >9, pill max 00, or bottle max 00 is invalid: cfg_err=1, stay IDLE. cfg_err clears on the next valid latch.
- IDLE:
  - If run=1 and config is valid: go to LOAD.
  - If bot_cnt equals the latched bottle max from the previous batch: clear bot_cnt on this transition.
- LOAD:
  - conv_req=1 until the cycle conv_ack=1 is sampled.
  - Next cycle: conv_req=0, pill_cnt=00, go to FILL.
- FILL (4-phase feed handshake):
  - feed_req rises; it is held until feed_ack=1 is sampled.
  - The same edge increments pill_cnt in BCD: l 9->0 carries into h; 99 is max.
  - feed_req is 0 for the next FEED_GAP+1 cycles before the next request.
  - When pill_cnt equals the latched pill max, go to NEXT; no further request is issued.
- NEXT (1 cycle):
  - Pulse bottle_done; increment bot_cnt in BCD.
  - If bot_cnt+1 equals the bottle max: go to FULL.
  - Else if conti=1: go to LOAD.
  - Else go to HOLD.
- HOLD: wait for run=0 then run=1 (internal edge detect), then go to LOAD. pill_cnt is held for display.
- FULL:
  - all_full=1 and counters are held.
  - When run=0: all_full=0, go to IDLE.
- run=0 mid-batch (LOAD/FILL):
  - An outstanding req is held until its ack is sampled, and a delivered pill is counted.
  - Then go to IDLE with pill_cnt cleared and bot_cnt retained.
  - A later run=1 resumes with a fresh bottle; bot_cnt is not cleared unless the batch had completed.
- An ack sampled while the corresponding req=0 is ignored.
- feed_req and conv_req are never asserted in the same cycle.

Optional Feature:
- FILL_TIMEOUT_EN defined:
  - A counter runs while feed_req or conv_req is high and resets on each new request.
  - On reaching TIMEOUT with no ack: drop req, set fault=1, go to FAULT.
  - FAULT exits to IDLE only on run=0, which clears fault and pill_cnt.
- Undefined: no counter, no FAULT state, fault tied 0, and the controller waits indefinitely for acks.

Test Plan:
- Pill max 03, bottle max 02, conti=1, acks returned 2 cycles after each req:
  - expect 2 conv handshakes and 6 feed handshakes;
  - bottle_done pulses twice;
  - final counts: pill 03, bot 02, all_full=1;
  - run=0 clears all_full.
- Pill max 12:
  - pill_cnt passes 09 -> 10 with a correct BCD carry;
  - gap between feed handshakes is exactly FEED_GAP+1 low cycles.
- conti=0, bottle max 03:
  - after the first bottle, the block sits in HOLD with busy=0;
  - run toggle 1->0->1 starts LOAD;
  - no conv_req appears without the toggle.
- Pill max 00, or pill_max_l=0xA:
  - cfg_err=1, no requests issued;
  - after correcting to 05 with run held high, the batch starts.
- run dropped while feed_req=1:
  - feed_req stays high until feed_ack, the pill is counted, then IDLE;
  - RST_n low mid-FILL clears every output asynchronously.
- With FILL_TIMEOUT_EN and TIMEOUT=8, feed_ack withheld:
  - fault=1 on cycle 8 and feed_req=0;
  - run=0 returns to IDLE with fault=0.

Source files
------------

// File: rtl/bottle_fill_seq.sv
// Bottling-lane sequencer: steps the conveyor, feeds pills one at a time with BCD counting, and repeats for a batch.
// Define FILL_TIMEOUT_EN to add the handshake timeout, the FAULT state and the fault output.
//
// state  | meaning
// IDLE   | waiting for run with a valid configuration
// LOAD   | conveyor request outstanding
// FILL   | pill feed handshakes and inter-feed gap
// NEXT   | bottle finished, bottle count advances
// HOLD   | step mode, waiting for a run toggle
// FULL   | batch complete, waiting for run low
// FAULT  | handshake timeout, waiting for run low
module bottle_fill_seq #(
    parameter int unsigned FEED_GAP = 1
`ifdef FILL_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       run,
    input  logic       conti,
    input  logic [3:0] pill_max_h,
    input  logic [3:0] pill_max_l,
    input  logic [3:0] bot_max_h,
    input  logic [3:0] bot_max_l,
    output logic       feed_req,
    input  logic       feed_ack,
    output logic       conv_req,
    input  logic       conv_ack,
    output logic [3:0] pill_cnt_h,
    output logic [3:0] pill_cnt_l,
    output logic [3:0] bot_cnt_h,
    output logic [3:0] bot_cnt_l,
    output logic       bottle_done,
    output logic       busy,
    output logic       all_full,
    output logic       cfg_err,
    output logic       fault
);

    localparam int GW = (FEED_GAP > 0) ? $clog2(FEED_GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_NEXT,
        S_HOLD,
        S_FULL
`ifdef FILL_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    state_t        state;
    logic [7:0]    pill_cnt;
    logic [7:0]    bot_cnt;
    logic [7:0]    pill_lim;
    logic [7:0]    bot_lim;
    logic [7:0]    pill_nxt;
    logic [7:0]    bot_nxt;
    logic [GW-1:0] gap_cnt;
    logic          run_low;
    logic          cfg_ok;

    // Two-digit BCD increment that saturates at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign pill_nxt = bcd_inc(pill_cnt);
    assign bot_nxt  = bcd_inc(bot_cnt);
    assign cfg_ok   = (pill_max_h <= 4'd9) && (pill_max_l <= 4'd9) &&
                      (bot_max_h  <= 4'd9) && (bot_max_l  <= 4'd9) &&
                      ({pill_max_h, pill_max_l} != 8'h00) &&
                      ({bot_max_h, bot_max_l} != 8'h00);

    assign {pill_cnt_h, pill_cnt_l} = pill_cnt;
    assign {bot_cnt_h, bot_cnt_l}   = bot_cnt;
    assign busy = !(state inside {S_IDLE, S_HOLD, S_FULL});

`ifdef FILL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;
    logic          tmo;

    // Reloads whenever no request is up, so each new request starts a fresh window.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            tmr <= TW'(TIMEOUT - 1);
        else if (!(feed_req || conv_req))
            tmr <= TW'(TIMEOUT - 1);
        else if (tmr != '0)
            tmr <= tmr - TW'(1);
    end

    assign tmo = (tmr == '0);
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= S_IDLE;
            pill_cnt    <= '0;
            bot_cnt     <= '0;
            pill_lim    <= '0;
            bot_lim     <= '0;
            gap_cnt     <= '0;
            run_low     <= 1'b0;
            feed_req    <= 1'b0;
            conv_req    <= 1'b0;
            bottle_done <= 1'b0;
            all_full    <= 1'b0;
            cfg_err     <= 1'b0;
`ifdef FILL_TIMEOUT_EN
            fault       <= 1'b0;
`endif
        end else begin
            bottle_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        if (cfg_ok) begin
                            pill_lim <= {pill_max_h, pill_max_l};
                            bot_lim  <= {bot_max_h, bot_max_l};
                            cfg_err  <= 1'b0;
                            if (bot_cnt == bot_lim)
                                bot_cnt <= '0;
                            conv_req <= 1'b1;
                            state    <= S_LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (conv_req && conv_ack) begin
                        conv_req <= 1'b0;
                        pill_cnt <= '0;
                        gap_cnt  <= '0;
                        state    <= run ? S_FILL : S_IDLE;
                    end
`ifdef FILL_TIMEOUT_EN
                    else if (tmo) begin
                        conv_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= S_FAULT;
                    end
`endif
                end
                S_FILL: begin
                    if (feed_req) begin
                        if (feed_ack) begin
                            feed_req <= 1'b0;
                            pill_cnt <= pill_nxt;
                            gap_cnt  <= GW'(FEED_GAP);
                        end
`ifdef FILL_TIMEOUT_EN
                        else if (tmo) begin
                            feed_req <= 1'b0;
                            fault    <= 1'b1;
                            state    <= S_FAULT;
                        end
`endif
                    end else if (!run) begin
                        pill_cnt <= '0;
                        state    <= S_IDLE;
                    end else if (pill_cnt == pill_lim) begin
                        bottle_done <= 1'b1;
                        state       <= S_NEXT;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else begin
                        feed_req <= 1'b1;
                    end
                end
                S_NEXT: begin
                    bot_cnt <= bot_nxt;
                    if (bot_nxt >= bot_lim) begin
                        all_full <= 1'b1;
                        state    <= S_FULL;
                    end else if (conti) begin
                        conv_req <= 1'b1;
                        state    <= S_LOAD;
                    end else begin
                        run_low <= 1'b0;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!run) begin
                        run_low <= 1'b1;
                    end else if (run_low) begin
                        conv_req <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_FULL: begin
                    if (!run) begin
                        all_full <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
`ifdef FILL_TIMEOUT_EN
                S_FAULT: begin
                    if (!run) begin
                        fault    <= 1'b0;
                        pill_cnt <= '0;
                        state    <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bottle_fill_seq.sv
// Directed and randomized bench for bottle_fill_seq; a handshake-level model counts pills, bottles and feed gaps.
module tb_bottle_fill_seq;

    localparam int GAP = 1;
    localparam int W_FULL = 0, W_FEED = 1, W_CONV = 2, W_IDLE = 3, W_DONE = 4, W_FAULT = 5;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       run = 1'b0;
    logic       conti = 1'b0;
    logic [3:0] pmh = '0, pml = '0, bmh = '0, bml = '0;
    logic       feed_req, feed_ack, conv_req, conv_ack;
    logic [3:0] pch, pcl, bch, bcl;
    logic       bottle_done, busy, all_full, cfg_err, fault;

    int checks = 0;
    int errors = 0;
    int n_feed = 0, n_conv = 0, n_done = 0;
    int model_pill = 0, model_bot = 0, pmax_m = 0;
    int gaps[$];
    bit in_gap = 0, prev_feed = 0, chk_pill = 0, chk_bot = 0;
    int gap_run = 0;
    bit hold_ack = 0;
    int lat_fix = 2;

    always #5 CLK = ~CLK;

    bottle_fill_seq #(
        .FEED_GAP(GAP)
`ifdef FILL_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .run(run), .conti(conti),
        .pill_max_h(pmh), .pill_max_l(pml), .bot_max_h(bmh), .bot_max_l(bml),
        .feed_req(feed_req), .feed_ack(feed_ack), .conv_req(conv_req), .conv_ack(conv_ack),
        .pill_cnt_h(pch), .pill_cnt_l(pcl), .bot_cnt_h(bch), .bot_cnt_l(bcl),
        .bottle_done(bottle_done), .busy(busy), .all_full(all_full),
        .cfg_err(cfg_err), .fault(fault)
    );

    function automatic logic [31:0] bcd(input int n);
        return 32'((n / 10) * 16 + (n % 10));
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int which, input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            case (which)
                W_FULL:  ok = all_full;
                W_FEED:  ok = feed_req;
                W_CONV:  ok = conv_req;
                W_IDLE:  ok = !busy;
                W_DONE:  ok = bottle_done;
                default: ok = fault;
            endcase
        end
        chk(32'(ok), 32'd1, {tag, "_reached"});
    endtask

    task automatic set_cfg(input int p, input int b);
        pmh = 4'(p / 10); pml = 4'(p % 10);
        bmh = 4'(b / 10); bml = 4'(b % 10);
        pmax_m = p;
    endtask

    task automatic clear_stats();
        n_feed = 0; n_conv = 0; n_done = 0;
        gaps.delete();
    endtask

    // Ack responder: acks a fixed or random number of cycles after each request.
    initial begin
        int fw, cw;
        fw = 0; cw = 0;
        feed_ack = 1'b0; conv_ack = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (!feed_req) begin
                feed_ack = 1'b0;
                fw = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            end else if (hold_ack) feed_ack = 1'b0;
            else if (fw == 0) feed_ack = 1'b1;
            else fw--;
            if (!conv_req) begin
                conv_ack = 1'b0;
                cw = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            end else if (cw == 0) conv_ack = 1'b1;
            else cw--;
        end
    end

    // Reference model: counts handshakes, tracks expected pill/bottle counts and feed gaps.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_n) begin
                chk_pill = 0; chk_bot = 0; in_gap = 0; prev_feed = 0;
            end else begin
                if (chk_pill) begin chk({24'd0, pch, pcl}, bcd(model_pill), "pill_cnt"); chk_pill = 0; end
                if (chk_bot)  begin chk({24'd0, bch, bcl}, bcd(model_bot), "bot_cnt");  chk_bot = 0;  end
                chk(32'(feed_req & conv_req), 32'd0, "req_exclusive");
                if (feed_req && !prev_feed && in_gap) begin
                    gaps.push_back(gap_run);
                    in_gap = 0;
                end
                if (conv_req && conv_ack) begin
                    n_conv++; model_pill = 0; chk_pill = 1; in_gap = 0;
                end
                if (feed_req && feed_ack) begin
                    n_feed++; model_pill++; chk_pill = 1; in_gap = 1; gap_run = 0;
                end else if (in_gap && !feed_req) begin
                    gap_run++;
                end
                if (bottle_done) begin
                    n_done++; model_bot++; chk_bot = 1; in_gap = 0;
                    chk({24'd0, pch, pcl}, bcd(pmax_m), "pill_at_done");
                end
                prev_feed = feed_req;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, b, fn;
        bit saw;
        #12;
        chk({25'd0, feed_req, conv_req, bottle_done, busy, all_full, cfg_err, fault}, 32'd0, "reset_flags");
        chk({16'd0, pch, pcl, bch, bcl}, 32'd0, "reset_counts");
        @(negedge CLK);
        RST_n = 1'b1;

        // Pill 03, bottle 02, continuous, acks two cycles late.
        set_cfg(3, 2); conti = 1'b1; lat_fix = 2; clear_stats();
        run = 1'b1;
        wait_for(W_FULL, 400, "t1_full");
        @(negedge CLK);
        chk(n_conv, 2, "t1_conv_count");
        chk(n_feed, 6, "t1_feed_count");
        chk(n_done, 2, "t1_done_count");
        chk({24'd0, pch, pcl}, 32'h03, "t1_pill_final");
        chk({24'd0, bch, bcl}, 32'h02, "t1_bot_final");
        chk(32'(all_full), 32'd1, "t1_all_full");
        chk(32'(busy), 32'd0, "t1_busy_full");
        run = 1'b0;
        repeat (2) @(negedge CLK);
        chk(32'(all_full), 32'd0, "t1_all_full_clear");
        model_bot = 0;

        // Pill 12 single bottle (BCD carry), then random batches with random ack latency.
        lat_fix = -1;
        for (int k = 0; k < 4; k++) begin
            p = (k == 0) ? 12 : int'($urandom_range(1, 25));
            b = (k == 0) ? 1  : int'($urandom_range(1, 3));
            set_cfg(p, b); clear_stats();
            run = 1'b1;
            wait_for(W_FULL, 2500, "t2_full");
            @(negedge CLK);
            chk(n_feed, p * b, "t2_feed_count");
            chk(n_conv, b, "t2_conv_count");
            chk(n_done, b, "t2_done_count");
            chk({24'd0, bch, bcl}, bcd(b), "t2_bot_final");
            chk(gaps.size(), (p - 1) * b, "t2_gap_count");
            foreach (gaps[i]) chk(gaps[i], GAP + 1, "t2_gap_len");
            run = 1'b0;
            repeat (2) @(negedge CLK);
            model_bot = 0;
        end

        // Step mode: HOLD until run toggles.
        conti = 1'b0; lat_fix = 1; set_cfg(2, 3); clear_stats();
        run = 1'b1;
        wait_for(W_DONE, 200, "t3_done1");
        repeat (3) @(negedge CLK);
        chk(32'(busy), 32'd0, "t3_hold_busy");
        saw = 1'b0;
        repeat (20) begin @(negedge CLK); saw |= conv_req; end
        chk(32'(saw), 32'd0, "t3_no_conv_without_toggle");
        run = 1'b0; repeat (2) @(negedge CLK); run = 1'b1;
        wait_for(W_CONV, 10, "t3_resume_conv");
        wait_for(W_DONE, 200, "t3_done2");
        repeat (3) @(negedge CLK);
        run = 1'b0; repeat (2) @(negedge CLK); run = 1'b1;
        wait_for(W_FULL, 200, "t3_full");
        @(negedge CLK);
        chk(n_done, 3, "t3_done_count");
        chk({24'd0, bch, bcl}, 32'h03, "t3_bot_final");
        run = 1'b0; repeat (2) @(negedge CLK);
        model_bot = 0;

        // Invalid configuration, then corrected with run held high.
        conti = 1'b1; set_cfg(0, 1); clear_stats();
        run = 1'b1;
        saw = 1'b0;
        repeat (10) begin @(negedge CLK); saw |= feed_req | conv_req; end
        chk(32'(cfg_err), 32'd1, "t4_cfg_err_zero");
        chk(32'(saw), 32'd0, "t4_no_req_zero");
        pmh = 4'h0; pml = 4'hA;
        repeat (5) begin @(negedge CLK); saw |= feed_req | conv_req; end
        chk(32'(cfg_err), 32'd1, "t4_cfg_err_hex");
        chk(32'(saw), 32'd0, "t4_no_req_hex");
        set_cfg(5, 1);
        wait_for(W_CONV, 10, "t4_start");
        chk(32'(cfg_err), 32'd0, "t4_cfg_err_clear");
        wait_for(W_FULL, 300, "t4_full");
        @(negedge CLK);
        chk({24'd0, pch, pcl}, 32'h05, "t4_pill_final");
        run = 1'b0; repeat (2) @(negedge CLK);
        model_bot = 0;

        // run dropped while feed_req is high in the second bottle.
        set_cfg(2, 3); lat_fix = 1; clear_stats();
        run = 1'b1;
        wait_for(W_DONE, 200, "t5_done1");
        hold_ack = 1'b1;
        wait_for(W_FEED, 50, "t5_feed");
        run = 1'b0;
        repeat (5) @(negedge CLK);
        chk(32'(feed_req), 32'd1, "t5_req_held");
        fn = n_feed;
        hold_ack = 1'b0;
        wait_for(W_IDLE, 20, "t5_idle");
        chk(n_feed, fn + 1, "t5_pill_counted");
        @(negedge CLK);
        chk({24'd0, pch, pcl}, 32'h00, "t5_pill_cleared");
        chk({24'd0, bch, bcl}, 32'h01, "t5_bot_kept");
        run = 1'b1;
        wait_for(W_FULL, 300, "t5_full");
        @(negedge CLK);
        chk(n_done, 3, "t5_done_count");
        chk({24'd0, bch, bcl}, 32'h03, "t5_bot_final");
        run = 1'b0; repeat (2) @(negedge CLK);
        model_bot = 0;

        // Asynchronous reset in the middle of filling.
        set_cfg(4, 2); clear_stats();
        run = 1'b1;
        wait_for(W_DONE, 200, "t6_done1");
        repeat (8) @(negedge CLK);
        wait_for(W_FEED, 50, "t6_feed");
        #2;
        RST_n = 1'b0;
        #1;
        chk({25'd0, feed_req, conv_req, bottle_done, busy, all_full, cfg_err, fault}, 32'd0, "t6_async_flags");
        chk({16'd0, pch, pcl, bch, bcl}, 32'd0, "t6_async_counts");
        run = 1'b0; model_bot = 0; model_pill = 0;
        @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) @(negedge CLK);

`ifdef FILL_TIMEOUT_EN
        // Feed ack withheld: fault after eight request cycles.
        set_cfg(3, 1); clear_stats(); hold_ack = 1'b1;
        run = 1'b1;
        wait_for(W_FEED, 50, "t7_feed");
        p = 0;
        while (!fault && p < 20) begin @(negedge CLK); p++; end
        chk(p, 8, "t7_fault_cycle");
        chk(32'(feed_req), 32'd0, "t7_req_dropped");
        run = 1'b0; hold_ack = 1'b0;
        repeat (2) @(negedge CLK);
        chk(32'(fault), 32'd0, "t7_fault_clear");
        chk(32'(busy), 32'd0, "t7_idle");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
